// File: rtl/instr_fetch.sv
// Three-phase instruction fetcher (ADDR -> DATA -> EXEC) with halt/resume handshake.
// Optional macro HALT_DETECT_EN: opcode 4'b0000 in EXEC also requests a halt.
module instr_fetch (
  input  logic        clk,
  input  logic        reset,
  input  logic        resume,
  input  logic        clk_dis,
  input  logic        jump_en,
  input  logic [11:0] jump_addr,
  input  logic [15:0] mem_rdata,
  output logic [11:0] mem_addr,
  output logic [15:0] pc,
  output logic [15:0] instr,
  output logic        instr_valid,
  output logic        fetch_clk,
  output logic        halted
);

  typedef enum logic [1:0] {
    S_ADDR = 2'd0,
    S_DATA = 2'd1,
    S_EXEC = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [11:0] r_pc;
  logic [11:0] w_next_pc;
  logic [15:0] r_instr;
  logic        r_instr_valid;
  logic        r_halted;
  logic        r_resume;
  logic        w_halt_req;
  logic        w_resume_edge;
  logic        w_load_instr;

  // Halt request seen in EXEC; outranks any jump request.
  always_comb begin
`ifdef HALT_DETECT_EN
    w_halt_req = clk_dis | (r_instr[15:12] == 4'b0000);
`else
    w_halt_req = clk_dis;
`endif
  end

  assign w_resume_edge = resume & ~r_resume;

  // Next-state and next-PC decode.
  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_load_instr = 1'b0;
    case (r_state)
      S_ADDR: begin
        w_next_state = S_DATA;
      end
      S_DATA: begin
        w_load_instr = 1'b1;
        w_next_state = S_EXEC;
      end
      S_EXEC: begin
        if (w_halt_req) begin
          w_next_state = S_HALT;
        end else if (jump_en) begin
          w_next_pc    = jump_addr;
          w_next_state = S_ADDR;
        end else begin
          w_next_pc    = r_pc + 12'd1;
          w_next_state = S_ADDR;
        end
      end
      S_HALT: begin
        if (w_resume_edge) begin
          w_next_pc    = r_pc + 12'd1;
          w_next_state = S_ADDR;
        end else begin
          w_next_state = S_HALT;
        end
      end
      default: begin
        w_next_state = S_ADDR;
      end
    endcase
  end

  // State, PC, captured instruction and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_ADDR;
      r_pc          <= 12'h000;
      r_instr       <= 16'h0000;
      r_instr_valid <= 1'b0;
      r_halted      <= 1'b0;
      r_resume      <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_pc          <= w_next_pc;
      r_instr_valid <= w_load_instr;
      r_halted      <= (w_next_state == S_HALT);
      r_resume      <= resume;
      if (w_load_instr) begin
        r_instr <= mem_rdata;
      end else begin
        r_instr <= r_instr;
      end
    end
  end

  assign mem_addr    = r_pc;
  assign pc          = {4'b0000, r_pc};
  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;
  assign fetch_clk   = r_instr_valid;
  assign halted      = r_halted;

endmodule

// File: tb/tb_instr_fetch.sv
// Randomised and directed bench for instr_fetch against an instruction-level reference model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        resume;
  logic        clk_dis;
  logic        jump_en;
  logic [11:0] jump_addr;
  logic [15:0] mem_rdata;
  logic [11:0] mem_addr;
  logic [15:0] pc;
  logic [15:0] instr;
  logic        instr_valid;
  logic        fetch_clk;
  logic        halted;

  logic [15:0] mem [0:4095];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: program counter, cycle within the current instruction, halt flag.
  int          m_pc;
  int          m_phase;
  logic [15:0] m_instr;
  bit          m_valid;
  bit          m_halted;
  bit          m_prev_res;

  always #5 clk = ~clk;

  always @(posedge clk) mem_rdata <= mem[mem_addr];

  instr_fetch dut (
    .clk        (clk),
    .reset      (reset),
    .resume     (resume),
    .clk_dis    (clk_dis),
    .jump_en    (jump_en),
    .jump_addr  (jump_addr),
    .mem_rdata  (mem_rdata),
    .mem_addr   (mem_addr),
    .pc         (pc),
    .instr      (instr),
    .instr_valid(instr_valid),
    .fetch_clk  (fetch_clk),
    .halted     (halted)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    bit hcond;
    if (reset) begin
      m_pc = 0; m_phase = 0; m_instr = 16'h0000;
      m_valid = 1'b0; m_halted = 1'b0; m_prev_res = 1'b0;
    end else begin
      m_valid = 1'b0;
      if (m_halted) begin
        if (resume && !m_prev_res) begin
          m_pc = (m_pc + 1) % 4096;
          m_halted = 1'b0;
          m_phase = 0;
        end
      end else if (m_phase == 0) begin
        m_phase = 1;
      end else if (m_phase == 1) begin
        m_instr = mem[12'(m_pc)];
        m_valid = 1'b1;
        m_phase = 2;
      end else begin
        hcond = clk_dis;
`ifdef HALT_DETECT_EN
        if (m_instr[15:12] == 4'h0) hcond = 1'b1;
`endif
        if (hcond) m_halted = 1'b1;
        else if (jump_en) m_pc = int'(jump_addr);
        else m_pc = (m_pc + 1) % 4096;
        m_phase = 0;
      end
      m_prev_res = resume;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("mem_addr", 32'(mem_addr), 32'(m_pc));
    check("pc", 32'(pc), 32'(m_pc));
    check("instr", 32'(instr), 32'(m_instr));
    check("instr_valid", 32'(instr_valid), 32'(m_valid));
    check("fetch_clk", 32'(fetch_clk), 32'(m_valid));
    check("halted", 32'(halted), 32'(m_halted));
  endtask

  task automatic run_to_exec();
    for (int i = 0; i < 6 && !(m_phase == 2 && !m_halted); i++) step();
    check("reach_exec", 32'(m_phase == 2 && !m_halted), 32'd1);
  endtask

  initial begin
    int nvalid;
    for (int i = 0; i < 4096; i++) mem[i] = {4'(1 + $urandom_range(14)), 12'($urandom)};
    mem[0] = 16'h4F0F;
    mem[1] = 16'h4F10;
    mem[12'h200] = 16'h0000;
    reset = 1'b1; resume = 1'b0; clk_dis = 1'b0; jump_en = 1'b0; jump_addr = 12'h000;

    // Reset, then two plain fetches.
    step(); step();
    reset = 1'b0;
    check("rst_mem_addr", 32'(mem_addr), 32'h000);
    check("rst_instr", 32'(instr), 32'h0000);
    step(); step();
    check("f0_valid", 32'(instr_valid), 32'd1);
    check("f0_instr", 32'(instr), 32'h4F0F);
    step();
    check("f1_addr", 32'(mem_addr), 32'h001);
    step(); step();
    check("f1_valid", 32'(instr_valid), 32'd1);
    check("f1_instr", 32'(instr), 32'h4F10);
    step();
    check("f2_addr", 32'(mem_addr), 32'h002);

    // Halt at 0x002, resume low for 20 cycles, then a rising edge.
    run_to_exec();
    clk_dis = 1'b1; step(); clk_dis = 1'b0;
    check("halt_entry", 32'(halted), 32'd1);
    nvalid = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      nvalid += int'(instr_valid);
    end
    check("halt_no_valid", 32'(nvalid), 32'd0);
    check("halt_addr", 32'(mem_addr), 32'h002);
    resume = 1'b1; step();
    check("resume_addr", 32'(mem_addr), 32'h003);
    check("resume_halted", 32'(halted), 32'd0);

    // Jump to 0x0FF.
    run_to_exec();
    jump_en = 1'b1; jump_addr = 12'h0FF; step(); jump_en = 1'b0;
    check("jump_addr", 32'(mem_addr), 32'h0FF);
    check("jump_pc", 32'(pc), 32'h00FF);

    // Resume already high at halt entry must not release.
    run_to_exec();
    clk_dis = 1'b1; step(); clk_dis = 1'b0;
    for (int i = 0; i < 8; i++) step();
    check("held_resume_halted", 32'(halted), 32'd1);
    resume = 1'b0; step(); resume = 1'b1; step();
    check("fresh_edge_halted", 32'(halted), 32'd0);
    check("fresh_edge_addr", 32'(mem_addr), 32'h100);

    // Wrap from 0xFFF, then simultaneous halt and jump.
    run_to_exec();
    jump_en = 1'b1; jump_addr = 12'hFFF; step(); jump_en = 1'b0;
    check("jump_fff", 32'(mem_addr), 32'hFFF);
    run_to_exec(); step();
    check("wrap_addr", 32'(mem_addr), 32'h000);
    run_to_exec();
    clk_dis = 1'b1; jump_en = 1'b1; jump_addr = 12'h555; step();
    clk_dis = 1'b0; jump_en = 1'b0;
    check("both_halted", 32'(halted), 32'd1);
    check("both_pc", 32'(pc), 32'h0000);
    resume = 1'b0; step(); resume = 1'b1; step();
    check("both_resume_addr", 32'(mem_addr), 32'h001);

    // Opcode 0000 at 0x200.
    run_to_exec();
    jump_en = 1'b1; jump_addr = 12'h200; step(); jump_en = 1'b0;
    run_to_exec(); step();
`ifdef HALT_DETECT_EN
    check("op0_halted", 32'(halted), 32'd1);
    check("op0_addr", 32'(mem_addr), 32'h200);
    resume = 1'b0; step(); resume = 1'b1; step();
    check("op0_resume_addr", 32'(mem_addr), 32'h201);
`else
    check("op0_halted", 32'(halted), 32'd0);
    check("op0_addr", 32'(mem_addr), 32'h201);
`endif

    // Reset in the middle of a fetch.
    step(); step();
    reset = 1'b1; step(); reset = 1'b0;
    check("midrst_addr", 32'(mem_addr), 32'h000);
    check("midrst_valid", 32'(instr_valid), 32'd0);
    check("midrst_instr", 32'(instr), 32'h0000);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      clk_dis   = ($urandom_range(7) == 0);
      jump_en   = ($urandom_range(3) == 0);
      jump_addr = 12'($urandom);
      if ($urandom_range(3) == 0) resume = ~resume;
      reset     = ($urandom_range(99) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have these ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- resume  input  1  restart request after halt; acted on at its rising edge only.
- clk_dis  input  1  halt request from datapath; sampled in EXEC.
- jump_en  input  1  jump request from datapath; sampled in EXEC.
- jump_addr  input  12  jump target.
- mem_rdata  input  16  instruction memory read data; valid one cycle after mem_addr.
- mem_addr  output  12  instruction memory address.
- pc  output  16  {4'b0000, current 12-bit address}.
- instr  output  16  last fetched instruction word.
- instr_valid  output  1  one-cycle strobe when instr updates.
- fetch_clk  output  1  equals instr_valid; datapath latch strobe.
- halted  output  1  high while in HALT.

Function
REQ-002 The block SHALL implement a four-state FSM: ADDR, DATA, EXEC, HALT.
REQ-003 ADDR: mem_addr driven with the current 12-bit PC; next state DATA.
REQ-004 DATA: instr <= mem_rdata; instr_valid and fetch_clk high for exactly this cycle; next state EXEC.
REQ-005 EXEC: if clk_dis=1, next state HALT and PC unchanged; else if jump_en=1, PC <= jump_addr, next state ADDR; else PC <= PC+1, next state ADDR.
REQ-006 clk_dis and jump_en both high in EXEC SHALL halt; the jump SHALL be discarded.
REQ-007 PC increment SHALL wrap 12'hFFF -> 12'h000 with no flag.
REQ-008 clk_dis and jump_en outside EXEC SHALL be ignored.
REQ-009 resume SHALL be registered internally; a rising edge is resume=1 with the previous-cycle registered value 0.
REQ-010 HALT: on a resume rising edge, PC <= PC+1 (wrapping), halted <= 0, next state ADDR; otherwise remain in HALT.
REQ-011 A resume held high across entry into HALT SHALL NOT release it; a fresh rising edge is required.
REQ-012 Resume edges outside HALT SHALL be ignored and not remembered.
REQ-013 halted SHALL be registered, high on every cycle in HALT and low otherwise.
REQ-014 Steady-state throughput SHALL be one instruction per 3 cycles; jump target reaches mem_addr in the cycle after EXEC.
REQ-015 instr SHALL hold its value between DATA cycles, including throughout HALT.

Reset
REQ-016 While reset=1 at a clock edge: state <= ADDR, PC <= 0, instr <= 16'h0000, instr_valid <= 0, fetch_clk <= 0, halted <= 0, resume register <= 0.
REQ-017 Reset SHALL take priority over all inputs in every state, including HALT and DATA mid-fetch; no partial fetch survives reset.
REQ-018 The first mem_addr after reset release SHALL be 12'h000.

Configuration
REQ-019 Macro HALT_DETECT_EN SHALL control local halt detection.
REQ-020 With HALT_DETECT_EN defined: in EXEC, instr[15:12]==4'b0000 SHALL be treated as clk_dis=1 (same priority over jump_en).
REQ-021 Without HALT_DETECT_EN: halting SHALL occur only via clk_dis; opcode 4'b0000 is fetched and advanced past like any other word.

Verification
REQ-022 The bench SHALL cover:
- Reset then memory words 0x4F0F, 0x4F10 at 0x000/0x001, no requests -> mem_addr 0x000, 0x001, 0x002 every 3 cycles; instr_valid strobes with instr 0x4F0F, 0x4F10.
- jump_en=1, jump_addr=0x0FF in EXEC -> next mem_addr 0x0FF, pc 0x00FF.
- clk_dis=1 in EXEC at PC 0x002 -> halted=1; resume held low 20 cycles -> mem_addr 0x002, no instr_valid; resume 0->1 -> mem_addr 0x003, halted=0.
- resume already high at halt entry and held for 8 cycles -> stays halted; drop then raise -> resumes.
- PC 0xFFF, no request -> next mem_addr 0x000; clk_dis+jump_en together -> halt, jump discarded.
- HALT_DETECT_EN defined, fetch 0x0000 with clk_dis=0 -> halted=1; undefined -> PC advances.
